// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM access arbiter.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_ADDR_W = 8;
    localparam int unsigned SRAM_DATA_W = 16;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        TURN
    } state_e;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Round-robin grant generator: search starts one past the last winner.
module sram_rr_arbiter #(
    parameter  int unsigned N_REQ = 2,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             update,
    output logic [N_REQ-1:0] grant_c
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx_c;
    logic             found;
    int               cand;

    always_comb begin
        grant_c = '0;
        idx_c   = ptr;
        found   = 1'b0;
        cand    = 0;
        for (int off = 1; off <= int'(N_REQ); off++) begin
            cand = (int'(ptr) + off) % int'(N_REQ);
            if (!found && req[cand]) begin
                found          = 1'b1;
                grant_c[cand]  = 1'b1;
                idx_c          = IDX_W'(cand);
            end
        end
    end

    // Pointer starts at the last requester so requester 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= IDX_W'(N_REQ - 1);
        end else if (update && found) begin
            ptr <= idx_c;
        end
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// Arbitrates requesters onto one async SRAM and sequences each access
// through setup, strobe, hold and turnaround phases.
module sram_access_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W        = SRAM_ADDR_W,
    parameter int unsigned DATA_W        = SRAM_DATA_W,
    parameter int unsigned N_REQ         = 2,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned TURN_CYCLES   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic [DATA_W-1:0]       rdata,
    output logic                    busy,
    output logic [ADDR_W-1:0]       address,
    inout  wire  [DATA_W-1:0]       data,
    output logic                    chip_enable,
    output logic                    write_enable,
    output logic                    output_enable
);

    localparam int unsigned CNT_MAX     = (ACCESS_CYCLES > TURN_CYCLES) ? ACCESS_CYCLES : TURN_CYCLES;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
    localparam int unsigned ACCESS_LAST = ACCESS_CYCLES - 1;
    localparam int unsigned TURN_LAST   = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;

    state_e             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [N_REQ-1:0]   win_c;
    logic               take, capture, in_txn, cur_we;
    logic [N_REQ-1:0]   cur_owner;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               we_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [N_REQ-1:0]   owner_q;
    logic               drive;
    logic [N_REQ-1:0]   gnt_n, done_n;
    logic               busy_n, ce_n, wen_n, oen_n, drive_n;

    sram_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .update  (state == IDLE),
        .grant_c (win_c)
    );

    // Winner's request fields, muxed by the one-hot grant.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (win_c[i]) begin
                sel_we    = we[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE:   if (|req) state_n = SETUP;
            SETUP: begin
                state_n = ACCESS;
                cnt_n   = '0;
            end
            ACCESS: begin
                if (cnt == CNT_W'(ACCESS_LAST)) state_n = HOLD;
                else                            cnt_n   = cnt + CNT_W'(1);
            end
            HOLD: begin
                state_n = (TURN_CYCLES == 0) ? IDLE : TURN;
                cnt_n   = '0;
            end
            TURN: begin
                if (cnt == CNT_W'(TURN_LAST)) state_n = IDLE;
                else                          cnt_n   = cnt + CNT_W'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    // Output values decoded from the next state so every pin is a flop.
    always_comb begin
        take      = (state == IDLE) && (|req);
        capture   = (state == ACCESS) && (state_n == HOLD) && !we_q;
        in_txn    = state_n inside {SETUP, ACCESS, HOLD};
        cur_we    = take ? sel_we : we_q;
        cur_owner = take ? win_c : owner_q;
        busy_n    = (state_n != IDLE);
        gnt_n     = in_txn ? cur_owner : '0;
        done_n    = ((state == ACCESS) && (state_n == HOLD)) ? owner_q : '0;
        ce_n      = in_txn ? STROBE_ON : STROBE_OFF;
        wen_n     = ((state_n == ACCESS) && cur_we)  ? STROBE_ON : STROBE_OFF;
        oen_n     = ((state_n == ACCESS) && !cur_we) ? STROBE_ON : STROBE_OFF;
        drive_n   = in_txn && cur_we;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            owner_q       <= '0;
            address       <= '0;
            rdata         <= '0;
            gnt           <= '0;
            done          <= '0;
            busy          <= 1'b0;
            chip_enable   <= STROBE_OFF;
            write_enable  <= STROBE_OFF;
            output_enable <= STROBE_OFF;
            drive         <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (take) begin
                we_q    <= sel_we;
                wdata_q <= sel_wdata;
                owner_q <= win_c;
                address <= sel_addr;
            end
            if (capture) rdata <= data;
            gnt           <= gnt_n;
            done          <= done_n;
            busy          <= busy_n;
            chip_enable   <= ce_n;
            write_enable  <= wen_n;
            output_enable <= oen_n;
            drive         <= drive_n;
        end
    end

    assign data = drive ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: default timing and a 1-cycle/no-turnaround
// variant share stimulus, each checked against a transaction-level model.
module tb_sram_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_clear;

    logic [1:0]  gnt0, done0, gnt1, done1;
    logic [15:0] rdata0, rdata1;
    logic        busy0, busy1, ce0, ce1, wen0, wen1, oe0, oe1;
    logic [7:0]  addr0, addr1;
    wire  [15:0] data0, data1;

    always #5 clk = ~clk;

    sram_access_arbiter dut0 (
        .clk(clk), .reset(reset), .req(req), .we(we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt0), .done(done0), .rdata(rdata0),
        .busy(busy0), .address(addr0), .data(data0), .chip_enable(ce0),
        .write_enable(wen0), .output_enable(oe0)
    );

    sram_access_arbiter #(.ACCESS_CYCLES(1), .TURN_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .req(req), .we(we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt1), .done(done1), .rdata(rdata1),
        .busy(busy1), .address(addr1), .data(data1), .chip_enable(ce1),
        .write_enable(wen1), .output_enable(oe1)
    );

    // Simple async SRAM per DUT: drives on CE&OE low, writes on a clock with CE&WE low.
    logic [15:0] sram0 [256];
    logic [15:0] sram1 [256];
    assign data0 = (!ce0 && !oe0) ? sram0[addr0] : 16'hzzzz;
    assign data1 = (!ce1 && !oe1) ? sram1[addr1] : 16'hzzzz;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int j = 0; j < 256; j++) begin
                sram0[j] <= 16'(j * 3 + 1);
                sram1[j] <= 16'(j * 3 + 1);
            end
        end else begin
            if (!ce0 && !wen0) sram0[addr0] <= data0;
            if (!ce1 && !wen1) sram1[addr1] <= data1;
        end
    end

    // Model: k = cycles since the arbitration edge (0 = idle).
    int          acc [2] = '{2, 1};
    int          trn [2] = '{1, 0};
    int          k   [2];
    int          own [2];
    int          last[2];
    logic        mwe [2];
    logic [7:0]  maddr[2];
    logic [15:0] mwd [2];
    logic [15:0] erd [2];
    logic [15:0] ref_mem [2][256];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int dcyc0[$], down0[$], dcyc1[$], down1[$];
    int ce_low0, wen_low0, oe_low0;

    task automatic cmp(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL inst%0d %s cyc %0d: got 0x%0h want 0x%0h", i, nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        k[i]     = 0;
        own[i]   = 0;
        last[i]  = 1;
        mwe[i]   = 1'b0;
        maddr[i] = 8'h00;
        mwd[i]   = 16'h0000;
        erd[i]   = 16'h0000;
    endtask

    task automatic advance(input int i);
        if (!reset) begin
            model_reset(i);
        end else if (k[i] == 0) begin
            if (req != 2'b00) begin
                int idx = -1;
                for (int off = 1; off <= 2; off++) begin
                    int c = (last[i] + off) % 2;
                    if (idx < 0 && req[c]) idx = c;
                end
                own[i]   = idx;
                last[i]  = idx;
                mwe[i]   = we[idx];
                maddr[i] = req_addr[idx*8 +: 8];
                mwd[i]   = req_wdata[idx*16 +: 16];
                k[i]     = 1;
            end
        end else if (k[i] < 2 + acc[i] + trn[i]) begin
            k[i]++;
            if (k[i] == 2 + acc[i]) begin
                if (mwe[i]) ref_mem[i][maddr[i]] = mwd[i];
                else        erd[i] = ref_mem[i][maddr[i]];
            end
        end else begin
            k[i] = 0;
        end
    endtask

    task automatic check_inst(input int i, input logic [1:0] g, input logic [1:0] d,
                              input logic [15:0] rd, input logic b, input logic [7:0] ad,
                              input logic [15:0] dt, input logic c, input logic w, input logic o);
        int   kk;
        logic owned, strobe;
        logic [1:0] oh;
        kk     = k[i];
        owned  = (kk >= 1) && (kk <= 2 + acc[i]);
        strobe = (kk >= 2) && (kk <= 1 + acc[i]);
        oh     = 2'(1 << own[i]);
        cmp(i, "busy",    32'(b),  32'(kk != 0));
        cmp(i, "gnt",     32'(g),  32'(owned ? oh : 2'b00));
        cmp(i, "done",    32'(d),  32'((kk == 2 + acc[i]) ? oh : 2'b00));
        cmp(i, "ce",      32'(c),  32'(!owned));
        cmp(i, "we_n",    32'(w),  32'(!(strobe && mwe[i])));
        cmp(i, "oe_n",    32'(o),  32'(!(strobe && !mwe[i])));
        cmp(i, "address", 32'(ad), 32'(maddr[i]));
        cmp(i, "rdata",   32'(rd), 32'(erd[i]));
        cmp(i, "gnt_onehot", 32'($onehot0(g)), 32'(1));
        cmp(i, "strobe_overlap", 32'(w | o), 32'(1));
        if (owned && mwe[i])   cmp(i, "data_wr", 32'(dt), 32'(mwd[i]));
        if (strobe && !mwe[i]) cmp(i, "data_rd", 32'(dt), 32'(ref_mem[i][maddr[i]]));
    endtask

    task automatic check_all();
        check_inst(0, gnt0, done0, rdata0, busy0, addr0, data0, ce0, wen0, oe0);
        check_inst(1, gnt1, done1, rdata1, busy1, addr1, data1, ce1, wen1, oe1);
        if (done0 != 2'b00) begin dcyc0.push_back(cyc); down0.push_back(done0[1] ? 1 : 0); end
        if (done1 != 2'b00) begin dcyc1.push_back(cyc); down1.push_back(done1[1] ? 1 : 0); end
        if (!ce0)  ce_low0++;
        if (!wen0) wen_low0++;
        if (!oe0)  oe_low0++;
    endtask

    task automatic step();
        for (int i = 0; i < 2; i++) advance(i);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic clear_obs();
        dcyc0 = {}; down0 = {}; dcyc1 = {}; down1 = {};
        ce_low0 = 0; wen_low0 = 0; oe_low0 = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy0 || busy1) && n < 60) begin
            step();
            n++;
        end
        cmp(0, "idle_timeout", 32'(n < 60), 32'(1));
    endtask

    task automatic wait_done0(input int cnt_needed);
        int n = 0;
        while (dcyc0.size() < cnt_needed && n < 40) begin
            step();
            n++;
        end
        cmp(0, "done_timeout", 32'(n < 40), 32'(1));
    endtask

    // Done pulses must appear at t0+first+j*period with owners alternating from owner0.
    task automatic check_series(input int i, input int t0, input int first, input int period,
                                input int n, input int owner0);
        int qc[$], qo[$];
        if (i == 0) begin qc = dcyc0; qo = down0; end
        else        begin qc = dcyc1; qo = down1; end
        cmp(i, "done_count", 32'(qc.size() >= n), 32'(1));
        for (int j = 0; j < n; j++) begin
            if (j < qc.size()) begin
                cmp(i, "done_cycle", 32'(qc[j] - t0), 32'(first + j * period));
                cmp(i, "done_owner", 32'(qo[j]), 32'((owner0 + j) % 2));
            end
        end
    endtask

    initial begin
        int t0;
        reset = 1'b0; req = 2'b00; we = 2'b00; req_addr = 16'h0; req_wdata = 32'h0;
        mem_clear = 1'b1;
        for (int j = 0; j < 256; j++) begin
            ref_mem[0][j] = 16'(j * 3 + 1);
            ref_mem[1][j] = 16'(j * 3 + 1);
        end
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        step();
        step();
        cmp(0, "rst_gnt",  32'(gnt0),   32'(0));
        cmp(0, "rst_busy", 32'(busy0),  32'(0));
        cmp(0, "rst_addr", 32'(addr0),  32'(0));
        cmp(0, "rst_rdata",32'(rdata0), 32'(0));
        cmp(0, "rst_strb", 32'({ce0, wen0, oe0}), 32'(3'b111));
        mem_clear = 1'b0;
        reset = 1'b1;
        step();

        // Requester 0 writes 0xBEEF to 0x12, then reads it back.
        clear_obs();
        req_addr = {8'h00, 8'h12}; req_wdata = {16'h0000, 16'hBEEF}; we = 2'b01; req = 2'b01;
        t0 = cyc;
        step();
        req = 2'b00;
        wait_done0(1);
        check_series(0, t0, 4, 6, 1, 0);
        cmp(0, "wr_we_low_cycles", 32'(wen_low0), 32'(2));
        wait_idle();

        clear_obs();
        we = 2'b00; req = 2'b01;
        t0 = cyc;
        step();
        req = 2'b00;
        wait_done0(1);
        check_series(0, t0, 4, 6, 1, 0);
        cmp(0, "rd_rdata", 32'(rdata0), 32'(16'hBEEF));
        cmp(1, "rd_rdata", 32'(rdata1), 32'(16'hBEEF));
        cmp(0, "rd_ce_low_cycles", 32'(ce_low0), 32'(4));
        cmp(0, "rd_oe_low_cycles", 32'(oe_low0), 32'(2));
        wait_idle();

        // Reset lands in the strobe phase of a write.
        req_addr = {8'h00, 8'h77}; req_wdata = {16'h0000, 16'h1234}; we = 2'b01; req = 2'b01;
        step();
        req = 2'b00;
        step();
        cmp(0, "pre_rst_we_n", 32'(wen0), 32'(0));
        reset = 1'b0;
        #1;
        cmp(0, "rst_mid_strb", 32'({ce0, wen0, oe0}), 32'(3'b111));
        cmp(1, "rst_mid_strb", 32'({ce1, wen1, oe1}), 32'(3'b111));
        cmp(0, "rst_mid_busy", 32'(busy0), 32'(0));
        cmp(0, "rst_mid_gnt",  32'(gnt0),  32'(0));
        model_reset(0);
        model_reset(1);
        clear_obs();
        step();
        step();
        cmp(0, "rst_no_done", 32'(dcyc0.size() + dcyc1.size()), 32'(0));
        reset = 1'b1;

        // Both requesters hold req: grants alternate starting with 0.
        clear_obs();
        req_addr = {8'h21, 8'h20}; req_wdata = {16'hB1B1, 16'hA0A0}; we = 2'b11; req = 2'b11;
        t0 = cyc;
        repeat (26) step();
        check_series(0, t0, 4, 6, 4, 0);
        check_series(1, t0, 3, 4, 4, 0);
        req = 2'b00;
        wait_idle();

        // Requester 1 reads then drops req mid-access; requester 0 writes next.
        clear_obs();
        req_addr = {8'h20, 8'h55}; req_wdata = {16'h0000, 16'h5555}; we = 2'b01; req = 2'b10;
        t0 = cyc;
        step();
        step();
        req = 2'b01;
        wait_done0(2);
        check_series(0, t0, 4, 6, 2, 1);
        check_series(1, t0, 3, 4, 2, 1);
        cmp(0, "rdata_kept", 32'(rdata0), 32'(16'hA0A0));
        cmp(1, "rdata_kept", 32'(rdata1), 32'(16'hA0A0));
        req = 2'b00;
        wait_idle();

        // Random traffic over a small address window.
        repeat (1500) begin
            req       = 2'($urandom_range(0, 3));
            we        = 2'($urandom_range(0, 3));
            req_addr  = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
            req_wdata = $urandom;
            step();
        end
        req = 2'b00;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_access_arbiter.md
# sram_access_arbiter

Shares the single `sram` instance (8-bit address, 16-bit bidirectional data, active-low chip/write/output enables) between several requesters, for example the I2C bridge and a host or initialisation port. It round-robin arbitrates among requesters and sequences each granted access through fixed setup, strobe, hold and turnaround phases. It is the only block that drives the SRAM control pins and its data bus. Requesters see a simple req/done handshake and never touch the SRAM pins directly.

## Interface
- `ADDR_W`, 8: SRAM address width.
- `DATA_W`, 16: SRAM data width.
- `N_REQ`, 2: number of requesters, ≥2; requester 0 wins first after reset.
- `ACCESS_CYCLES`, 2: cycles the WE/OE strobe is held low, ≥1.
- `TURN_CYCLES`, 1: idle bus-turnaround cycles after each access, ≥0.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request level.
- `we`  in  N_REQ  per-requester direction (1 = write, 0 = read).
- `req_addr`  in  N_REQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  N_REQ*DATA_W  packed write data.
- `gnt`  out  N_REQ  one-hot; high for the whole owned transaction.
- `done`  out  N_REQ  one-cycle completion pulse to the owner.
- `rdata`  out  DATA_W  read result, shared by all requesters.
- `busy`  out  1  high in any state other than IDLE.
- `address`  out  ADDR_W  SRAM address.
- `data`  inout  DATA_W  SRAM data bus; driven only for writes.
- `chip_enable`, `write_enable`, `output_enable`  out  1 each  SRAM strobes, active low.

## Operation
- FSM states and transitions:
  - IDLE → SETUP when any `req` bit is high.
  - SETUP → ACCESS.
  - ACCESS → HOLD after ACCESS_CYCLES cycles.
  - HOLD → TURN, or → IDLE if TURN_CYCLES = 0.
  - TURN → IDLE after TURN_CYCLES cycles.
- Arbitration happens only in IDLE. Search starts at the requester after the last winner, wrapping modulo N_REQ. The pointer resets to N_REQ-1.
- On the arbitration edge, latch the winner's `we`, `req_addr` and `req_wdata`. Later changes to those inputs are ignored until `done`.
- Strobes by state:
  - SETUP: chip_enable=0; write_enable and output_enable stay 1.
  - ACCESS, write: write_enable=0.
  - ACCESS, read: output_enable=0.
  - HOLD: chip_enable=0; write_enable and output_enable return to 1.
  - TURN and IDLE: all three strobes = 1.
- `address` holds the latched address from SETUP through HOLD. Outside those states it keeps its last value.
- `data` is driven with the latched wdata from SETUP through HOLD on writes. It is high-Z in every other state and on all reads.
- Reads: `data` is sampled into `rdata` on the final ACCESS edge. `rdata` holds that value until the next read completes; writes leave it unchanged.
- `done[owner]` pulses in HOLD. `gnt[owner]` is high from SETUP through HOLD.
- If a requester drops `req` mid-transaction, the transaction still completes and `done` still pulses.
- If `req` is still high after `done`, it counts as a new request at the next IDLE, subject to round-robin.
- Non-owning requesters' inputs are ignored.

## Timing
- With the request present at IDLE edge t:
  - SETUP at t+1, ACCESS at t+2..t+1+ACCESS_CYCLES, HOLD (with `done`) at t+2+ACCESS_CYCLES.
  - Defaults: `done` at t+4; back-to-back period 1+1+ACCESS_CYCLES+1+TURN_CYCLES = 6 cycles.
- Every output is registered, so no combinational path exists from `req` to any output.
- Reset values:
  - gnt=0, done=0, rdata=0, busy=0, address=0.
  - chip_enable=1, write_enable=1, output_enable=1, data=Z.
  - FSM in IDLE.
- Reset asserted mid-access raises all strobes and releases `data` immediately, without waiting for a clock. The aborted transaction gets no `done`.
- Simultaneous requests resolve by round-robin order. A lone requester is granted on every IDLE visit.

## Structure
- Package `sram_ctrl_pkg` holds:
  - the state enum (IDLE, SETUP, ACCESS, HOLD, TURN);
  - default ADDR_W and DATA_W;
  - the active-low strobe constants (STROBE_ON=0, STROBE_OFF=1).
- Sub-module `sram_rr_arbiter`: a round-robin grant generator (req, update enable → one-hot grant, pointer), parameterised by N_REQ.
- Top level: FSM, phase counter, latches, tristate driver.

## Test plan
- Requester 0 writes addr 0x12 / 0xBEEF, then reads addr 0x12 → `rdata`=0xBEEF.
  - `done[0]` pulses at t+4 on each access.
  - write_enable is low exactly 2 cycles, with `data` stable from SETUP through HOLD.
- Both requesters hold `req` continuously → grants alternate 0,1,0,1. Each `done` is 6 cycles apart and `gnt` is never multi-hot.
- Read strobe check: chip_enable low 4 cycles and output_enable low 2 cycles. The bench checks that `data` is never driven by this block while output_enable=0.
- Reset pulled low during ACCESS of a write → all strobes go to 1 and `data` to Z within the same cycle, with no `done`. After release, requester 0 is granted first.
- Requester 1 drops `req` during ACCESS → `done[1]` still pulses. Requester 0 is served next, and `rdata` keeps its last read value across the writes.
- Sweep ACCESS_CYCLES=1 with TURN_CYCLES=0 → back-to-back period of 4 cycles. No strobe overlaps between adjacent accesses.
